bcd_alu_sequencer: RTL

Multi-cycle arithmetic unit behind the calculator's control FSM. It takes the 8-digit BCD operand registers and the 2-bit operator. On an `execute` strobe it sequences digit-serial add, subtract or multiply through one shared BCD digit ALU. It returns a BCD result with sign, overflow and error flags to the display mux.

---
 rtl/calc_pkg.sv | 24 ++
 rtl/bcd_alu_sequencer_if.sv | 31 +++
 rtl/bcd_digit_alu.sv | 34 +++
 rtl/bcd_alu_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator arithmetic path: operator codes,
// sequencer states and the default operand width in BCD digits.
package calc_pkg;

    localparam int DIGITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        SUB,
        SUBSWAP,
        MUL_SHIFT,
        MUL_ADD,
        FINISH
    } state_t;

endpackage

// File: rtl/bcd_alu_sequencer_if.sv
// Command/result bundle between the calculator control FSM (master) and the
// BCD arithmetic sequencer (slave).
interface bcd_alu_sequencer_if
    import calc_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT
);

    logic                  execute;
    logic                  clear;
    logic [1:0]            operator;
    logic [4*DIGITS-1:0]   reg_A;
    logic [4*DIGITS-1:0]   reg_B;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   reg_result;
    logic                  negative;
    logic                  overflow;
    logic                  error;

    modport master (
        output execute, clear, operator, reg_A, reg_B,
        input  busy, done, reg_result, negative, overflow, error
    );

    modport slave (
        input  execute, clear, operator, reg_A, reg_B,
        output busy, done, reg_result, negative, overflow, error
    );

endinterface

// File: rtl/bcd_digit_alu.sv
// Combinational single-digit BCD adder/subtractor; cout is carry for add and
// borrow for subtract. Inputs are assumed to be valid BCD digits.
module bcd_digit_alu (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] y,
    output logic       cout
);

    logic [4:0] sum;
    logic [4:0] diff;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
        diff = {1'b0, a} - {1'b0, b} - {4'd0, cin};
        y    = sum[3:0];
        cout = 1'b0;
        if (sub) begin
            // A negative difference wraps; adding ten in 4 bits yields the BCD digit
            if (diff[4]) begin
                y    = diff[3:0] + 4'd10;
                cout = 1'b1;
            end else begin
                y    = diff[3:0];
            end
        end else if (sum > 5'd9) begin
            y    = sum[3:0] + 4'd6;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_alu_sequencer.sv
// Digit-serial BCD add/subtract/multiply sequencer sharing one digit ALU.
// state | meaning: IDLE wait | ADD a+b | SUB a-b | SUBSWAP b-a after borrow | MUL_SHIFT acc<<digit | MUL_ADD acc+=a | FINISH result/done
module bcd_alu_sequencer
    import calc_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                clock,
    input  logic                reset_n,
    bcd_alu_sequencer_if.slave  bus
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   dig_q, dig_d;
    logic [CW-1:0]   mdig_q, mdig_d;
    logic [3:0]      rep_q, rep_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [W-1:0]    result_q, result_d;
    logic            neg_q, neg_d;
    logic            ovf_q, ovf_d;
    logic            err_q, err_d;

    logic [3:0]      alu_a, alu_b, alu_y;
    logic            alu_sub, alu_cout;
    logic            fin, fin_ovf, fin_neg, fin_err;
    logic [W-1:0]    a_rot, b_rot, b_rotl, acc_in, acc_shl;
    logic [3:0]      msd_out, b_msd;
    logic            last_dig, last_mdig;

    function automatic logic all_bcd(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    bcd_digit_alu u_digit_alu (
        .a    (alu_a),
        .b    (alu_b),
        .cin  (carry_q),
        .sub  (alu_sub),
        .y    (alu_y),
        .cout (alu_cout)
    );

    always_comb begin
        alu_a   = a_q[3:0];
        alu_b   = b_q[3:0];
        alu_sub = 1'b0;
        case (state_q)
            SUB: alu_sub = 1'b1;
            SUBSWAP: begin
                alu_a   = b_q[3:0];
                alu_b   = a_q[3:0];
                alu_sub = 1'b1;
            end
            MUL_ADD: begin
                alu_a = acc_q[3:0];
                alu_b = a_q[3:0];
            end
            default: ;
        endcase
    end

    // Operands rotate so they are back in place after a full DIGITS-cycle pass
    assign a_rot     = {a_q[3:0], a_q[W-1:4]};
    assign b_rot     = {b_q[3:0], b_q[W-1:4]};
    assign b_rotl    = {b_q[W-5:0], b_q[W-1:W-4]};
    assign acc_in    = {alu_y, acc_q[W-1:4]};
    assign acc_shl   = {acc_q[W-5:0], 4'd0};
    assign msd_out   = acc_q[W-1:W-4];
    assign b_msd     = b_q[W-1:W-4];
    assign last_dig  = (dig_q == '0);
    assign last_mdig = (mdig_q == '0);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        dig_d    = dig_q;
        mdig_d   = mdig_q;
        rep_d    = rep_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        fin      = 1'b0;
        fin_ovf  = 1'b0;
        fin_neg  = 1'b0;
        fin_err  = 1'b0;

        if (bus.clear) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            result_d = '0;
            neg_d    = 1'b0;
            ovf_d    = 1'b0;
            err_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE, FINISH: begin
                    state_d = IDLE;
                    if (bus.execute) begin
                        a_d      = bus.reg_A;
                        b_d      = bus.reg_B;
                        acc_d    = '0;
                        carry_d  = 1'b0;
                        dig_d    = CNT_LAST;
                        mdig_d   = CNT_LAST;
                        rep_d    = 4'd0;
                        result_d = '0;
                        neg_d    = 1'b0;
                        ovf_d    = 1'b0;
                        err_d    = 1'b0;
                        if (bus.operator == OP_RSVD || !all_bcd(bus.reg_A) || !all_bcd(bus.reg_B)) begin
                            fin     = 1'b1;
                            fin_err = 1'b1;
                        end else begin
                            busy_d = 1'b1;
                            case (op_t'(bus.operator))
                                OP_ADD:  state_d = ADD;
                                OP_SUB:  state_d = SUB;
                                default: state_d = MUL_SHIFT;
                            endcase
                        end
                    end
                end

                ADD, SUB, SUBSWAP: begin
                    a_d     = a_rot;
                    b_d     = b_rot;
                    acc_d   = acc_in;
                    carry_d = alu_cout;
                    dig_d   = dig_q - CNT_ONE;
                    if (last_dig) begin
                        carry_d = 1'b0;
                        dig_d   = CNT_LAST;
                        if (state_q == ADD) begin
                            fin     = 1'b1;
                            fin_ovf = alu_cout;
                        end else if (state_q == SUB) begin
                            if (alu_cout) state_d = SUBSWAP;
                            else          fin     = 1'b1;
                        end else begin
                            fin     = 1'b1;
                            fin_neg = 1'b1;
                        end
                    end
                end

                MUL_SHIFT: begin
                    acc_d = acc_shl;
                    b_d   = b_rotl;
                    rep_d = b_msd;
                    if (msd_out != 4'd0) begin
                        fin     = 1'b1;
                        fin_ovf = 1'b1;
                    end else if (b_msd != 4'd0) begin
                        state_d = MUL_ADD;
                        dig_d   = CNT_LAST;
                        carry_d = 1'b0;
                    end else if (last_mdig) begin
                        fin = 1'b1;
                    end else begin
                        mdig_d = mdig_q - CNT_ONE;
                    end
                end

                MUL_ADD: begin
                    a_d     = a_rot;
                    acc_d   = acc_in;
                    carry_d = alu_cout;
                    dig_d   = dig_q - CNT_ONE;
                    if (last_dig) begin
                        carry_d = 1'b0;
                        dig_d   = CNT_LAST;
                        if (alu_cout) begin
                            fin     = 1'b1;
                            fin_ovf = 1'b1;
                        end else if (rep_q != 4'd1) begin
                            rep_d = rep_q - 4'd1;
                        end else if (last_mdig) begin
                            fin = 1'b1;
                        end else begin
                            mdig_d  = mdig_q - CNT_ONE;
                            state_d = MUL_SHIFT;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end

        if (fin) begin
            state_d  = FINISH;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            ovf_d    = fin_ovf;
            err_d    = fin_err;
            neg_d    = fin_neg & ~fin_ovf & ~fin_err;
            result_d = (fin_ovf || fin_err) ? '0 : acc_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            dig_q    <= '0;
            mdig_q   <= '0;
            rep_q    <= 4'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            dig_q    <= dig_d;
            mdig_q   <= mdig_d;
            rep_q    <= rep_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.reg_result = result_q;
    assign bus.negative   = neg_q;
    assign bus.overflow   = ovf_q;
    assign bus.error      = err_q;

endmodule
